// File: rtl/mio_bus_responder.sv
// Data-side bus target for the CPU: decodes each load/store to RAM, LED, switches or the timer block
// and completes it with a one-cycle cpu_ready pulse carrying cpu_rdata.
module mio_bus_responder #(
    parameter int RAM_AW = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic              cpu_we,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_ready,
    output logic              cpu_int,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              ram_we,
    input  logic [31:0]       ram_rdata,
    input  logic [15:0]       sw_in,
    output logic [15:0]       led_out,
    output logic [1:0]        dbg_state
);

    // Handshake: a request is taken only in IDLE; cpu_req/addr/wdata/we stay stable until the
    // single-cycle cpu_ready pulse, and a request still held in the following IDLE is a new one.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RAM_RD = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    localparam logic [31:0] A_LED  = 32'hE000_0000;
    localparam logic [31:0] A_SW   = 32'hF000_0000;
    localparam logic [31:0] A_CNT  = 32'hF000_0004;
    localparam logic [31:0] A_CMP  = 32'hF000_0008;
    localparam logic [31:0] A_CTRL = 32'hF000_000C;
    localparam logic [31:0] A_STAT = 32'hF000_0010;

    state_e      state_q, state_d;
    logic [31:0] rdata_q, rdata_d;
    logic [15:0] led_q, led_d;
    logic [15:0] sw_meta_q, sw_meta_d;
    logic [15:0] sw_sync_q, sw_sync_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic [1:0]  ctrl_q, ctrl_d;
    logic        irq_q, irq_d;
    logic        err_q, err_d;

    logic [31:0] addr_w;
    logic        is_ram, sel_led, sel_sw, sel_cnt, sel_cmp, sel_ctrl, sel_stat, unmapped;
    logic        accept, wr;
    logic        timer_match, irq_set;
    logic [31:0] periph_rdata;

    always_comb begin
        addr_w   = cpu_addr & 32'hFFFF_FFFC;
        is_ram   = (cpu_addr[31:RAM_AW+2] == '0);
        sel_led  = (addr_w == A_LED);
        sel_sw   = (addr_w == A_SW);
        sel_cnt  = (addr_w == A_CNT);
        sel_cmp  = (addr_w == A_CMP);
        sel_ctrl = (addr_w == A_CTRL);
        sel_stat = (addr_w == A_STAT);
        unmapped = !(is_ram || sel_led || sel_sw || sel_cnt || sel_cmp || sel_ctrl || sel_stat);
        // rst_n gates acceptance so a request held across reset never strobes the RAM.
        accept   = (state_q == ST_IDLE) && cpu_req && rst_n;
        wr       = accept && cpu_we;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (accept) state_d = (is_ram && !cpu_we) ? ST_RAM_RD : ST_RESP;
            ST_RAM_RD: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        cpu_ready = (state_q == ST_RESP);
        ram_we    = wr && is_ram;
        ram_addr  = rst_n ? cpu_addr[RAM_AW+1:2] : '0;
        ram_wdata = cpu_wdata;
        cpu_rdata = rdata_q;
        cpu_int   = irq_q && ctrl_q[1];
        led_out   = led_q;
        dbg_state = state_q;
    end

    always_comb begin
        periph_rdata = '0;
        if (sel_led)  periph_rdata = {16'h0000, led_q};
        if (sel_sw)   periph_rdata = {16'h0000, sw_sync_q};
        if (sel_cnt)  periph_rdata = count_q;
        if (sel_cmp)  periph_rdata = compare_q;
        if (sel_ctrl) periph_rdata = {30'd0, ctrl_q};
        if (sel_stat) periph_rdata = {30'd0, err_q, irq_q};
    end

    always_comb begin
        rdata_d = rdata_q;
        if (accept)                     rdata_d = (!cpu_we && !is_ram) ? periph_rdata : '0;
        else if (state_q == ST_RAM_RD)  rdata_d = ram_rdata;

        led_d     = (wr && sel_led)  ? cpu_wdata[15:0] : led_q;
        compare_d = (wr && sel_cmp)  ? cpu_wdata       : compare_q;
        ctrl_d    = (wr && sel_ctrl) ? cpu_wdata[1:0]  : ctrl_q;
        sw_meta_d = sw_in;
        sw_sync_d = sw_meta_q;

        // Auto-reload timer; a CPU write to count overrides both the reload and the irq.
        timer_match = ctrl_q[0] && (count_q == compare_q);
        count_d     = count_q;
        if (ctrl_q[0]) count_d = timer_match ? 32'd0 : count_q + 32'd1;
        if (wr && sel_cnt) count_d = cpu_wdata;
        irq_set = timer_match && !(wr && sel_cnt);

        irq_d = irq_q;
        if (wr && sel_stat && cpu_wdata[0]) irq_d = 1'b0;
        if (irq_set)                        irq_d = 1'b1;

        err_d = err_q;
        if (wr && sel_stat && cpu_wdata[1]) err_d = 1'b0;
        if (accept && unmapped)             err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q   <= '0;
            led_q     <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            count_q   <= '0;
            compare_q <= 32'hFFFF_FFFF;
            ctrl_q    <= '0;
            irq_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            rdata_q   <= rdata_d;
            led_q     <= led_d;
            sw_meta_q <= sw_meta_d;
            sw_sync_q <= sw_sync_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ctrl_q    <= ctrl_d;
            irq_q     <= irq_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_mio_bus_responder.sv
// Bench for mio_bus_responder: directed scenarios plus randomized RAM/LED/switch traffic,
// checked against a behavioural model of the address map, memory contents and timer timeline.
module tb_mio_bus_responder;

    localparam int RAM_AW = 10;
    localparam int TCMP   = 5;

    logic              clk;
    logic              rst_n;
    logic              cpu_req;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_wdata;
    logic              cpu_we;
    logic [31:0]       cpu_rdata;
    logic              cpu_ready;
    logic              cpu_int;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic              ram_we;
    logic [31:0]       ram_rdata;
    logic [15:0]       sw_in;
    logic [15:0]       led_out;
    logic [1:0]        dbg_state;

    mio_bus_responder #(.RAM_AW(RAM_AW)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_rdata(cpu_rdata),
        .cpu_ready(cpu_ready), .cpu_int(cpu_int), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
        .sw_in(sw_in), .led_out(led_out), .dbg_state(dbg_state)
    );

    // Clock, cycle counter and the synchronous RAM the responder drives.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] ram_mem [0:(1<<RAM_AW)-1];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        ram_rdata <= ram_mem[ram_addr];
    end

    // Scoreboard state
    int total = 0;
    int bad   = 0;
    logic [31:0] exp_mem [int];
    int          written_q[$];
    logic [15:0] exp_led;

    // Results of the most recent access
    logic [31:0]       r_data;
    int                r_lat;
    int                r_wecnt;
    logic [RAM_AW-1:0] r_addr0;
    logic              r_int;
    int                r_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request at posedge+1; returns at posedge+1 of the cycle after the ready pulse.
    task automatic access(input logic we, input logic [31:0] a, input logic [31:0] d);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        r_lat = -1; r_wecnt = 0; r_data = 'x; r_int = 1'bx; r_acc = cyc; r_addr0 = 'x;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) r_addr0 = ram_addr;
            if (ram_we) r_wecnt++;
            if (cpu_ready) begin
                r_lat = k; r_data = cpu_rdata; r_int = cpu_int;
                break;
            end
        end
        @(posedge clk); #1;
        cpu_req = 1'b0;
    endtask

    task automatic wait_phase(input int en, input int p);
        for (int g = 0; g < 20; g++) begin
            if (((cyc - en) % (TCMP + 1)) == p) break;
            @(posedge clk); #1;
        end
    endtask

    int          en_cyc, rise_cyc, wr_cyc, pulses, w;
    logic [3:0]  pat;
    logic [31:0] d, a;

    initial begin
        rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; sw_in = '0;
        exp_led = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, cpu_ready}, 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);
        chk("rst_int", {31'd0, cpu_int}, 32'd0);
        chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
        chk("rst_led", {16'd0, led_out}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // RAM store then load
        access(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        chk("st_lat", r_lat, 32'd1);
        chk("st_we_cycles", r_wecnt, 32'd1);
        chk("st_ram_addr", {22'd0, r_addr0}, 32'd4);
        exp_mem[4] = 32'hDEAD_BEEF; written_q.push_back(4);
        access(1'b0, 32'h0000_0010, 32'h0);
        chk("ld_lat", r_lat, 32'd2);
        chk("ld_data", r_data, 32'hDEAD_BEEF);
        chk("ld_we_cycles", r_wecnt, 32'd0);

        // Reset in the middle of a RAM load
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0010;
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", {31'd0, cpu_ready}, 32'd0);
        chk("mid_rst_rdata", cpu_rdata, 32'd0);
        chk("mid_rst_ram_we", {31'd0, ram_we}, 32'd0);
        chk("mid_rst_ram_addr", {22'd0, ram_addr}, 32'd0);
        chk("mid_rst_int", {31'd0, cpu_int}, 32'd0);
        cpu_req = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (cpu_ready) pulses++;
        end
        chk("no_stray_ready", pulses, 32'd0);
        @(posedge clk); #1;
        access(1'b0, 32'h0000_0010, 32'h0);
        chk("ram_kept", r_data, 32'hDEAD_BEEF);

        // Peripheral reset values
        access(1'b0, 32'hF000_0004, 32'h0);
        chk("cnt_rst", r_data, 32'd0);
        access(1'b0, 32'hF000_0008, 32'h0);
        chk("cmp_rst", r_data, 32'hFFFF_FFFF);
        access(1'b0, 32'hF000_000C, 32'h0);
        chk("ctrl_rst", r_data, 32'd0);
        access(1'b0, 32'hF000_0010, 32'h0);
        chk("stat_rst", r_data, 32'd0);

        // LED and switches
        access(1'b1, 32'hE000_0000, 32'h0000_A5A5);
        exp_led = 16'hA5A5;
        chk("led_out", {16'd0, led_out}, 32'h0000_A5A5);
        chk("led_lat", r_lat, 32'd1);
        access(1'b0, 32'hE000_0000, 32'h0);
        chk("led_rd", r_data, 32'h0000_A5A5);
        sw_in = 16'h1234;
        repeat (2) @(posedge clk);
        #1;
        access(1'b0, 32'hF000_0000, 32'h0);
        chk("sw_rd", r_data, 32'h0000_1234);
        chk("sw_lat", r_lat, 32'd1);

        // Timer: period is compare+1 cycles starting the cycle after ctrl is written
        access(1'b1, 32'hF000_0008, TCMP);
        access(1'b1, 32'hF000_000C, 32'd3);
        en_cyc = r_acc + 1;
        rise_cyc = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (cpu_int) begin
                rise_cyc = cyc;
                break;
            end
        end
        chk("int_rise_cycle", rise_cyc, en_cyc + TCMP + 1);
        @(posedge clk); #1;
        wait_phase(en_cyc, 0);
        access(1'b0, 32'hF000_0004, 32'h0);
        chk("cnt_after_match", r_data, 32'd0);
        access(1'b0, 32'hF000_0004, 32'h0);
        chk("cnt_running", r_data, (r_acc - en_cyc) % (TCMP + 1));

        wait_phase(en_cyc, TCMP);
        access(1'b1, 32'hF000_0010, 32'd1);
        chk("set_beats_clear", {31'd0, r_int}, 32'd1);
        wait_phase(en_cyc, 0);
        access(1'b1, 32'hF000_0010, 32'd1);
        chk("int_cleared", {31'd0, r_int}, 32'd0);
        access(1'b0, 32'hF000_0010, 32'h0);
        chk("stat_cleared", r_data, 32'd0);

        wait_phase(en_cyc, TCMP);
        access(1'b1, 32'hF000_0004, 32'd100);
        wr_cyc = r_acc;
        chk("cnt_wr_no_irq", {31'd0, r_int}, 32'd0);
        repeat (10) @(posedge clk);
        #1;
        chk("no_irq_later", {31'd0, cpu_int}, 32'd0);
        access(1'b0, 32'hF000_0004, 32'h0);
        chk("cnt_after_wr", r_data, 32'd100 + (r_acc - (wr_cyc + 1)));

        // Unmapped access and held request
        access(1'b0, 32'h8000_0000, 32'h0);
        chk("unm_rdata", r_data, 32'd0);
        chk("unm_lat", r_lat, 32'd1);
        access(1'b0, 32'hF000_0010, 32'h0);
        chk("unm_err", r_data, 32'd2);
        access(1'b1, 32'hF000_0010, 32'd2);
        access(1'b0, 32'hF000_0010, 32'h0);
        chk("err_cleared", r_data, 32'd0);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h8000_0000;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            pat[k] = cpu_ready;
        end
        @(posedge clk); #1;
        cpu_req = 1'b0;
        chk("b2b_pattern", {28'd0, pat}, 32'h0000_000A);
        repeat (2) @(posedge clk);
        #1;

        // Randomized traffic against the model
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: begin
                    w = $urandom_range(0, (1 << RAM_AW) - 1);
                    d = $urandom;
                    a = (w << 2) | $urandom_range(0, 3);
                    access(1'b1, a, d);
                    chk("rnd_st_lat", r_lat, 32'd1);
                    chk("rnd_st_we", r_wecnt, 32'd1);
                    chk("rnd_st_addr", {22'd0, r_addr0}, w);
                    if (!exp_mem.exists(w)) written_q.push_back(w);
                    exp_mem[w] = d;
                end
                1: begin
                    w = written_q[$urandom_range(0, written_q.size() - 1)];
                    a = (w << 2) | $urandom_range(0, 3);
                    access(1'b0, a, 32'h0);
                    chk("rnd_ld_lat", r_lat, 32'd2);
                    chk("rnd_ld_data", r_data, exp_mem[w]);
                    chk("rnd_ld_we", r_wecnt, 32'd0);
                end
                2: begin
                    d = $urandom;
                    access(1'b1, 32'hE000_0000 | $urandom_range(0, 3), d);
                    exp_led = d[15:0];
                    chk("rnd_led_out", {16'd0, led_out}, {16'd0, exp_led});
                    access(1'b0, 32'hE000_0000, 32'h0);
                    chk("rnd_led_rd", r_data, {16'd0, exp_led});
                end
                default: begin
                    d = $urandom;
                    sw_in = d[15:0];
                    repeat (2) @(posedge clk);
                    #1;
                    access(1'b0, 32'hF000_0000, 32'h0);
                    chk("rnd_sw_rd", r_data, {16'd0, d[15:0]});
                end
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
